l1_to_l2_request_arbiter: RTL and testbench

Downstream neighbour of the four per-processor L1 cache FSMs (L1a..L1d) and upstream of the shared L2 cache FSM. Accepts level-held read-allocate, inclusion-write and write-back requests from NUM_PORTS L1 ports and grants one at a time, round-robin. Forwards the winning request to L2 as a single level-held request, then routes L2's completion back to the granted L1 as a one-cycle pulse. Includes a response watchdog that aborts transactions L2 never completes.

---
 rtl/l1_to_l2_request_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_l1_to_l2_request_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_to_l2_request_arbiter.sv
// Round-robin arbiter funnelling L1 read/inclusion-write/write-back requests into the single L2 port.
// One transaction is in flight at a time; a watchdog aborts transactions that L2 never completes.
module l1_to_l2_request_arbiter #(
    parameter int NUM_PORTS              = 4,
    parameter int ADDRESS_WIDTH          = 32,
    parameter int DATA_WIDTH             = 32,
    parameter int MAIN_MEMORY_DATA_WIDTH = 128,
    parameter int TIMEOUT_CYCLES         = 64,
    localparam int PORT_W                = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_PORTS-1:0]                        l1_read_req_i,
    input  logic [NUM_PORTS-1:0]                        l1_write_req_i,
    input  logic [NUM_PORTS-1:0]                        l1_write_back_req_i,
    input  logic [NUM_PORTS*ADDRESS_WIDTH-1:0]          l1_address_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]             l1_write_data_i,
    input  logic [NUM_PORTS*MAIN_MEMORY_DATA_WIDTH-1:0] l1_write_back_data_i,
    output logic [NUM_PORTS-1:0]                        l1_ready_o,
    output logic [NUM_PORTS-1:0]                        l1_write_verified_o,
    output logic [NUM_PORTS-1:0]                        l1_write_back_verified_o,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0]           l1_read_block_o,
    output logic [ADDRESS_WIDTH-1:0]                    l2_address_o,
    output logic                                        l2_read_req_o,
    output logic                                        l2_write_req_o,
    output logic                                        l2_write_back_req_o,
    output logic [DATA_WIDTH-1:0]                       l2_write_data_o,
    output logic [MAIN_MEMORY_DATA_WIDTH-1:0]           l2_write_back_data_o,
    input  logic                                        l2_ready_i,
    input  logic                                        l2_write_verified_i,
    input  logic                                        l2_write_back_verified_i,
    input  logic [MAIN_MEMORY_DATA_WIDTH-1:0]           l2_read_block_i,
    output logic [PORT_W-1:0]                           grant_port_o,
    output logic                                        busy_o,
    output logic                                        timeout_error_o
);

    localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_e;
    typedef enum logic [1:0] {REQ_READ, REQ_WRITE, REQ_WB} req_e;

    state_e                            state_q;
    req_e                              type_q;
    req_e                              type_d;
    logic [PORT_W-1:0]                 ptr_q;
    logic [PORT_W-1:0]                 port_q;
    logic [PORT_W-1:0]                 port_d;
    logic [PORT_W-1:0]                 ptr_d;
    logic                              found_d;
    logic                              done_d;
    logic [WDOG_W-1:0]                 wdog_q;
    logic [NUM_PORTS-1:0]              active_d;
    logic [NUM_PORTS-1:0]              onehot_d;
    logic [NUM_PORTS-1:0]              l1_ready_q;
    logic [NUM_PORTS-1:0]              l1_wv_q;
    logic [NUM_PORTS-1:0]              l1_wbv_q;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0] read_block_q;
    logic [ADDRESS_WIDTH-1:0]          address_q;
    logic [DATA_WIDTH-1:0]             wdata_q;
    logic [MAIN_MEMORY_DATA_WIDTH-1:0] wbdata_q;
    logic                              rd_req_q;
    logic                              wr_req_q;
    logic                              wb_req_q;
    logic [PORT_W-1:0]                 grant_q;
    logic                              timeout_q;

    assign active_d = l1_read_req_i | l1_write_req_i | l1_write_back_req_i;
    assign onehot_d = NUM_PORTS'(1) << port_q;
    assign ptr_d    = (port_q == PORT_W'(NUM_PORTS - 1)) ? '0 : port_q + 1'b1;
    assign done_d   = (type_q == REQ_READ  && l2_ready_i) ||
                      (type_q == REQ_WRITE && l2_write_verified_i) ||
                      (type_q == REQ_WB    && l2_write_back_verified_i);

    // First requesting port at or above the pointer, wrapping around.
    always_comb begin
        found_d = 1'b0;
        port_d  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found_d && active_d[(int'(ptr_q) + i) % NUM_PORTS]) begin
                found_d = 1'b1;
                port_d  = PORT_W'((int'(ptr_q) + i) % NUM_PORTS);
            end
        end
    end

    // Write-back outranks inclusion write, which outranks read, within one port.
    always_comb begin
        if (l1_write_back_req_i[port_d]) begin
            type_d = REQ_WB;
        end else if (l1_write_req_i[port_d]) begin
            type_d = REQ_WRITE;
        end else begin
            type_d = REQ_READ;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            type_q       <= REQ_READ;
            ptr_q        <= '0;
            port_q       <= '0;
            wdog_q       <= '0;
            l1_ready_q   <= '0;
            l1_wv_q      <= '0;
            l1_wbv_q     <= '0;
            read_block_q <= '0;
            address_q    <= '0;
            wdata_q      <= '0;
            wbdata_q     <= '0;
            rd_req_q     <= 1'b0;
            wr_req_q     <= 1'b0;
            wb_req_q     <= 1'b0;
            grant_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        port_q    <= port_d;
                        grant_q   <= port_d;
                        type_q    <= type_d;
                        address_q <= l1_address_i[int'(port_d)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                        wdata_q   <= l1_write_data_i[int'(port_d)*DATA_WIDTH +: DATA_WIDTH];
                        wbdata_q  <= l1_write_back_data_i[int'(port_d)*MAIN_MEMORY_DATA_WIDTH +: MAIN_MEMORY_DATA_WIDTH];
                        rd_req_q  <= (type_d == REQ_READ);
                        wr_req_q  <= (type_d == REQ_WRITE);
                        wb_req_q  <= (type_d == REQ_WB);
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog_q  <= '0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    if (done_d) begin
                        rd_req_q   <= 1'b0;
                        wr_req_q   <= 1'b0;
                        wb_req_q   <= 1'b0;
                        l1_ready_q <= (type_q == REQ_READ)  ? onehot_d : '0;
                        l1_wv_q    <= (type_q == REQ_WRITE) ? onehot_d : '0;
                        l1_wbv_q   <= (type_q == REQ_WB)    ? onehot_d : '0;
                        if (type_q == REQ_READ) begin
                            read_block_q <= l2_read_block_i;
                        end
                        state_q <= RESPOND;
                    end else if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abort: withdraw the request and report, but never pulse the L1.
                        rd_req_q  <= 1'b0;
                        wr_req_q  <= 1'b0;
                        wb_req_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        state_q   <= RESPOND;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                RESPOND: begin
                    l1_ready_q   <= '0;
                    l1_wv_q      <= '0;
                    l1_wbv_q     <= '0;
                    read_block_q <= '0;
                    grant_q      <= '0;
                    ptr_q        <= ptr_d;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign l1_ready_o               = l1_ready_q;
    assign l1_write_verified_o      = l1_wv_q;
    assign l1_write_back_verified_o = l1_wbv_q;
    assign l1_read_block_o          = read_block_q;
    assign l2_address_o             = address_q;
    assign l2_read_req_o            = rd_req_q;
    assign l2_write_req_o           = wr_req_q;
    assign l2_write_back_req_o      = wb_req_q;
    assign l2_write_data_o          = wdata_q;
    assign l2_write_back_data_o     = wbdata_q;
    assign grant_port_o             = grant_q;
    assign busy_o                   = (state_q != IDLE);
    assign timeout_error_o          = timeout_q;

endmodule

// File: tb/tb_l1_to_l2_request_arbiter.sv
// Directed bench for the L1-to-L2 request arbiter: reset, single read, round-robin order,
// in-port priority, stray completions, watchdog abort and reset mid-transaction.
module tb_l1_to_l2_request_arbiter;

    localparam int NP = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 128;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     rd_req;
    logic [NP-1:0]     wr_req;
    logic [NP-1:0]     wb_req;
    logic [NP*AW-1:0]  l1_addr;
    logic [NP*DW-1:0]  l1_wdata;
    logic [NP*MW-1:0]  l1_wbdata;
    logic [NP-1:0]     l1_ready;
    logic [NP-1:0]     l1_wv;
    logic [NP-1:0]     l1_wbv;
    logic [MW-1:0]     l1_block;
    logic [AW-1:0]     l2_addr;
    logic              l2_rd;
    logic              l2_wr;
    logic              l2_wb;
    logic [DW-1:0]     l2_wdata;
    logic [MW-1:0]     l2_wbdata;
    logic              l2_ready;
    logic              l2_wv;
    logic              l2_wbv;
    logic [MW-1:0]     l2_block;
    logic [1:0]        grant;
    logic              busy;
    logic              tmo;

    int passed = 0;
    int total  = 0;

    localparam logic [MW-1:0] BLK   = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [MW-1:0] WBBLK = 128'hFEED_FACE_0000_1111_2222_3333_4444_5555;
    localparam logic [MW-1:0] BLK2  = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;

    always #5 clk = ~clk;

    l1_to_l2_request_arbiter #(
        .NUM_PORTS(NP), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW),
        .MAIN_MEMORY_DATA_WIDTH(MW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .l1_read_req_i(rd_req), .l1_write_req_i(wr_req), .l1_write_back_req_i(wb_req),
        .l1_address_i(l1_addr), .l1_write_data_i(l1_wdata), .l1_write_back_data_i(l1_wbdata),
        .l1_ready_o(l1_ready), .l1_write_verified_o(l1_wv), .l1_write_back_verified_o(l1_wbv),
        .l1_read_block_o(l1_block), .l2_address_o(l2_addr),
        .l2_read_req_o(l2_rd), .l2_write_req_o(l2_wr), .l2_write_back_req_o(l2_wb),
        .l2_write_data_o(l2_wdata), .l2_write_back_data_o(l2_wbdata),
        .l2_ready_i(l2_ready), .l2_write_verified_i(l2_wv), .l2_write_back_verified_i(l2_wbv),
        .l2_read_block_i(l2_block), .grant_port_o(grant), .busy_o(busy), .timeout_error_o(tmo)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_l2_req(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (l2_rd || l2_wr || l2_wb) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if ({l2_rd, l2_wr, l2_wb} !== 3'b000) $display("FAIL reset_l2_req got=%b exp=000", {l2_rd, l2_wr, l2_wb}); else passed++;
        total++; if ({l1_ready, l1_wv, l1_wbv} !== 12'h000) $display("FAIL reset_l1_pulse got=%h exp=000", {l1_ready, l1_wv, l1_wbv}); else passed++;
        total++; if ({grant, busy, tmo} !== 4'b0000) $display("FAIL reset_status got=%b exp=0000", {grant, busy, tmo}); else passed++;
        total++; if (l1_block !== '0) $display("FAIL reset_block got=%h exp=0", l1_block); else passed++;
    endtask

    task automatic test_single_read();
        bit seen;
        int cnt;
        rd_req[2] = 1'b1;
        l1_addr[2*AW +: AW] = 32'h8000_0040;
        wait_l2_req(seen);
        total++; if (seen !== 1'b1) $display("FAIL sr_req_seen got=%b exp=1", seen); else passed++;
        total++; if (grant !== 2'd2) $display("FAIL sr_grant got=%0d exp=2", grant); else passed++;
        total++; if (l2_addr !== 32'h8000_0040) $display("FAIL sr_addr got=%h exp=80000040", l2_addr); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL sr_busy got=%b exp=1", busy); else passed++;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin
            if (l2_rd) cnt++;
            if (c < 3) tick();
        end
        l2_ready = 1'b1;
        l2_block = BLK;
        tick();
        total++; if (cnt !== 4) $display("FAIL sr_req_cycles got=%0d exp=4", cnt); else passed++;
        total++; if (l2_rd !== 1'b0) $display("FAIL sr_req_drop got=%b exp=0", l2_rd); else passed++;
        total++; if (l1_ready !== 4'b0100) $display("FAIL sr_l1_ready got=%b exp=0100", l1_ready); else passed++;
        total++; if (l1_block !== BLK) $display("FAIL sr_block got=%h exp=%h", l1_block, BLK); else passed++;
        l2_ready = 1'b0;
        l2_block = '0;
        rd_req[2] = 1'b0;
        tick();
        total++; if (l1_ready !== 4'b0000) $display("FAIL sr_pulse_end got=%b exp=0000", l1_ready); else passed++;
        total++; if ({grant, busy} !== 3'b000) $display("FAIL sr_idle got=%b exp=000", {grant, busy}); else passed++;
        total++; if (l1_block !== '0) $display("FAIL sr_block_idle got=%h exp=0", l1_block); else passed++;
    endtask

    task automatic test_round_robin();
        bit seen;
        int order [4] = '{0, 1, 3, 0};
        logic [NP-1:0] exp_pulse;
        logic [MW-1:0] blk;
        apply_reset();
        rd_req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            wait_l2_req(seen);
            total++; if (seen !== 1'b1) $display("FAIL rr_req_seen_%0d got=%b exp=1", k, seen); else passed++;
            total++; if (grant !== 2'(order[k])) $display("FAIL rr_grant_%0d got=%0d exp=%0d", k, grant, order[k]); else passed++;
            tick();
            tick();
            blk = MW'(k + 100);
            l2_ready = 1'b1;
            l2_block = blk;
            tick();
            exp_pulse = 4'b0001 << order[k];
            total++; if (l1_ready !== exp_pulse) $display("FAIL rr_pulse_%0d got=%b exp=%b", k, l1_ready, exp_pulse); else passed++;
            total++; if (l1_block !== blk) $display("FAIL rr_block_%0d got=%h exp=%h", k, l1_block, blk); else passed++;
            l2_ready = 1'b0;
            // Port 0 keeps its request up after its first service: that is its re-request.
            if (k != 0) rd_req[order[k]] = 1'b0;
            tick();
        end
        rd_req = '0;
    endtask

    task automatic test_writeback_priority();
        bit seen;
        wb_req[1] = 1'b1;
        rd_req[1] = 1'b1;
        l1_addr[1*AW +: AW] = 32'h0000_1230;
        l1_wbdata[1*MW +: MW] = WBBLK;
        wait_l2_req(seen);
        total++; if (seen !== 1'b1) $display("FAIL wb_req_seen got=%b exp=1", seen); else passed++;
        total++; if ({l2_rd, l2_wr, l2_wb} !== 3'b001) $display("FAIL wb_type got=%b exp=001", {l2_rd, l2_wr, l2_wb}); else passed++;
        total++; if (grant !== 2'd1) $display("FAIL wb_grant got=%0d exp=1", grant); else passed++;
        total++; if (l2_wbdata !== WBBLK) $display("FAIL wb_data got=%h exp=%h", l2_wbdata, WBBLK); else passed++;
        total++; if (l2_addr !== 32'h0000_1230) $display("FAIL wb_addr got=%h exp=00001230", l2_addr); else passed++;
        tick();
        tick();
        l2_wbv = 1'b1;
        tick();
        total++; if (l1_wbv !== 4'b0010) $display("FAIL wb_pulse got=%b exp=0010", l1_wbv); else passed++;
        total++; if (l1_ready !== 4'b0000) $display("FAIL wb_no_ready got=%b exp=0000", l1_ready); else passed++;
        l2_wbv = 1'b0;
        wb_req[1] = 1'b0;
        tick();
        wait_l2_req(seen);
        total++; if ({l2_rd, l2_wr, l2_wb} !== 3'b100) $display("FAIL wb_then_rd_type got=%b exp=100", {l2_rd, l2_wr, l2_wb}); else passed++;
        total++; if (grant !== 2'd1) $display("FAIL wb_then_rd_grant got=%0d exp=1", grant); else passed++;
        tick();
        tick();
        l2_ready = 1'b1;
        l2_block = BLK2;
        tick();
        total++; if (l1_ready !== 4'b0010) $display("FAIL wb_then_rd_pulse got=%b exp=0010", l1_ready); else passed++;
        total++; if (l1_wbv !== 4'b0000) $display("FAIL wb_then_rd_no_wbv got=%b exp=0000", l1_wbv); else passed++;
        l2_ready = 1'b0;
        rd_req[1] = 1'b0;
        tick();
    endtask

    task automatic test_stray_completion();
        bit seen;
        wr_req[3] = 1'b1;
        l1_wdata[3*DW +: DW] = 32'hDEAD_BEEF;
        wait_l2_req(seen);
        total++; if ({l2_rd, l2_wr, l2_wb} !== 3'b010) $display("FAIL wr_type got=%b exp=010", {l2_rd, l2_wr, l2_wb}); else passed++;
        total++; if (grant !== 2'd3) $display("FAIL wr_grant got=%0d exp=3", grant); else passed++;
        total++; if (l2_wdata !== 32'hDEAD_BEEF) $display("FAIL wr_data got=%h exp=deadbeef", l2_wdata); else passed++;
        tick();
        l2_ready = 1'b1;
        tick();
        tick();
        total++; if (l2_wr !== 1'b1) $display("FAIL wr_stray_held got=%b exp=1", l2_wr); else passed++;
        total++; if ({l1_ready, l1_wv} !== 8'h00) $display("FAIL wr_stray_no_pulse got=%h exp=00", {l1_ready, l1_wv}); else passed++;
        l2_ready = 1'b0;
        l2_wv = 1'b1;
        tick();
        total++; if (l1_wv !== 4'b1000) $display("FAIL wr_pulse got=%b exp=1000", l1_wv); else passed++;
        total++; if (l1_ready !== 4'b0000) $display("FAIL wr_no_ready got=%b exp=0000", l1_ready); else passed++;
        total++; if (l2_wr !== 1'b0) $display("FAIL wr_req_drop got=%b exp=0", l2_wr); else passed++;
        l2_wv = 1'b0;
        wr_req[3] = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bit seen;
        int cnt;
        rd_req[0] = 1'b1;
        wait_l2_req(seen);
        total++; if (grant !== 2'd0) $display("FAIL to_grant got=%0d exp=0", grant); else passed++;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (!l2_rd) break;
            cnt++;
            tick();
        end
        // One ISSUE cycle plus TO cycles of WAIT.
        total++; if (cnt !== TO + 1) $display("FAIL to_req_cycles got=%0d exp=%0d", cnt, TO + 1); else passed++;
        total++; if (tmo !== 1'b1) $display("FAIL to_flag got=%b exp=1", tmo); else passed++;
        total++; if (l1_ready !== 4'b0000) $display("FAIL to_no_pulse got=%b exp=0000", l1_ready); else passed++;
        rd_req[0] = 1'b0;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL to_idle got=%b exp=0", busy); else passed++;
        total++; if (tmo !== 1'b1) $display("FAIL to_sticky got=%b exp=1", tmo); else passed++;
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        wr_req[2] = 1'b1;
        wait_l2_req(seen);
        tick();
        tick();
        total++; if ({busy, l2_wr} !== 2'b11) $display("FAIL rw_in_wait got=%b exp=11", {busy, l2_wr}); else passed++;
        reset = 1'b1;
        tick();
        total++; if ({l2_rd, l2_wr, l2_wb} !== 3'b000) $display("FAIL rw_req_withdrawn got=%b exp=000", {l2_rd, l2_wr, l2_wb}); else passed++;
        total++; if ({grant, busy, tmo} !== 4'b0000) $display("FAIL rw_status got=%b exp=0000", {grant, busy, tmo}); else passed++;
        reset = 1'b0;
        wr_req[2] = 1'b0;
        rd_req = 4'b1001;
        wait_l2_req(seen);
        total++; if (grant !== 2'd0) $display("FAIL rw_ptr_zero got=%0d exp=0", grant); else passed++;
        tick();
        tick();
        l2_ready = 1'b1;
        tick();
        total++; if (l1_ready !== 4'b0001) $display("FAIL rw_pulse got=%b exp=0001", l1_ready); else passed++;
        l2_ready = 1'b0;
        rd_req = '0;
        tick();
    endtask

    initial begin
        reset     = 1'b1;
        rd_req    = '0;
        wr_req    = '0;
        wb_req    = '0;
        l1_addr   = '0;
        l1_wdata  = '0;
        l1_wbdata = '0;
        l2_ready  = 1'b0;
        l2_wv     = 1'b0;
        l2_wbv    = 1'b0;
        l2_block  = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_writeback_priority();
        test_stray_completion();
        test_timeout();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit got=expired exp=finished");
        $fatal(1, "[TB] time limit reached");
    end

endmodule
